// File: rtl/ram_simple_dual_flow.sv
// Simple dual-port RAM with a zero-fill clear sequencer, an optional same-address
// write bypass, a 1- or 2-cycle read pipeline and a 2-entry output FIFO that
// absorbs consumer backpressure.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | normal operation, reads and writes accepted
// ST_CLEAR | zero written to address clr_cnt_q each cycle, ports blocked
module ram_simple_dual_flow #(
    parameter int W          = 16,
    parameter int D          = 128,
    parameter int RD_LAT     = 1,
    parameter int BYPASS     = 1,
    parameter int CLR_ON_RST = 1,
    localparam int AW        = $clog2(D)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    output logic          busy,
    input  logic          we,
    input  logic [AW-1:0] write_addr,
    input  logic [W-1:0]  din,
    input  logic          re,
    input  logic [AW-1:0] read_addr,
    output logic          rd_req_rdy,
    output logic          dout_vld,
    output logic [W-1:0]  dout,
    input  logic          dout_rdy
);

    localparam logic [0:0]    ST_IDLE   = 1'b0;
    localparam logic [0:0]    ST_CLEAR  = 1'b1;
    localparam logic [AW-1:0] LAST_ADDR = AW'(D - 1);
    localparam logic [AW:0]   DEPTH     = (AW + 1)'(D);

    logic [0:0]    state_q, state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic          init_q;

    logic [W-1:0]  mem_q [D];

    logic              wr_en, rd_acc, rd_in_range;
    logic [W-1:0]      rd_data_now;
    logic [RD_LAT-1:0] pipe_vld_q;
    logic [W-1:0]      pipe_data_q [RD_LAT];
    logic              ret_vld;
    logic [W-1:0]      ret_data;

    logic [W-1:0] fifo0_q, fifo0_d, fifo1_q, fifo1_d;
    logic [1:0]   fifo_cnt_q, fifo_cnt_d;
    logic         fifo_empty, push, pop_fifo, pop;
    logic [2:0]   inflight, total;

    assign busy = (state_q == ST_CLEAR);

    // Clear sequencer next-state: one address per cycle, exactly D cycles
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (init_q || clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; init_q requests the post-reset clear on the first edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= '0;
            init_q    <= (CLR_ON_RST != 0);
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            init_q    <= 1'b0;
        end
    end

    assign wr_en       = we && !busy && ({1'b0, write_addr} < DEPTH);
    assign rd_in_range = ({1'b0, read_addr} < DEPTH);

    // Storage array; the clear sequence owns the write port while busy
    always_ff @(posedge clk) begin
        if (busy) begin
            mem_q[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            mem_q[write_addr] <= din;
        end
    end

    // Read data at acceptance: out-of-range reads give zero, collisions honour BYPASS
    always_comb begin
        rd_data_now = '0;
        if (rd_in_range) begin
            if ((BYPASS != 0) && wr_en && (write_addr == read_addr)) begin
                rd_data_now = din;
            end else begin
                rd_data_now = mem_q[read_addr];
            end
        end
    end

    assign rd_acc = re && rd_req_rdy;

    // Read pipeline, RD_LAT stages deep; reset discards anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= rd_acc;
            if (rd_acc) begin
                pipe_data_q[0] <= rd_data_now;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    assign ret_vld  = pipe_vld_q[RD_LAT-1];
    assign ret_data = pipe_data_q[RD_LAT-1];

    // Empty FIFO lets returning data straight through to dout
    assign fifo_empty = (fifo_cnt_q == 2'd0);
    assign dout_vld   = !fifo_empty || ret_vld;
    assign dout       = fifo_empty ? ret_data : fifo0_q;
    assign pop        = dout_vld && dout_rdy;
    assign pop_fifo   = !fifo_empty && dout_rdy;
    assign push       = ret_vld && !(fifo_empty && dout_rdy);

    // Credit check counts the entry leaving this cycle as already free, which
    // keeps one accept per cycle under full drain with either read latency
    assign inflight   = 3'($countones(pipe_vld_q));
    assign total      = inflight + {1'b0, fifo_cnt_q};
    assign rd_req_rdy = !rst && !busy && !init_q && ((total - {2'b00, pop}) < 3'd2);

    // FIFO next-state: head is always fifo0
    always_comb begin
        fifo0_d    = fifo0_q;
        fifo1_d    = fifo1_q;
        fifo_cnt_d = fifo_cnt_q;
        case ({push, pop_fifo})
            2'b10: begin
                if (fifo_empty) fifo0_d = ret_data;
                else            fifo1_d = ret_data;
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                fifo0_d    = fifo1_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    fifo0_d = ret_data;
                end else begin
                    fifo0_d = fifo1_q;
                    fifo1_d = ret_data;
                end
            end
            default: ;
        endcase
    end

    // FIFO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo0_q    <= '0;
            fifo1_q    <= '0;
            fifo_cnt_q <= '0;
        end else begin
            fifo0_q    <= fifo0_d;
            fifo1_q    <= fifo1_d;
            fifo_cnt_q <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_ram_simple_dual_flow.sv
// Directed bench: instance A uses defaults (D=128, RD_LAT=1, BYPASS=1, auto clear),
// instance B uses D=100, RD_LAT=2, BYPASS=0, no auto clear.
module tb_ram_simple_dual_flow;

    localparam int W  = 16;
    localparam int AW = 7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          clr_a, we_a, re_a, dout_rdy_a;
    logic [AW-1:0] write_addr_a, read_addr_a;
    logic [W-1:0]  din_a;
    logic          busy_a, rd_req_rdy_a, dout_vld_a;
    logic [W-1:0]  dout_a;

    logic          clr_b, we_b, re_b, dout_rdy_b;
    logic [AW-1:0] write_addr_b, read_addr_b;
    logic [W-1:0]  din_b;
    logic          busy_b, rd_req_rdy_b, dout_vld_b;
    logic [W-1:0]  dout_b;

    int n_cmp = 0;
    int n_err = 0;

    ram_simple_dual_flow u_dut_a (
        .clk(clk), .rst(rst), .clr(clr_a), .busy(busy_a),
        .we(we_a), .write_addr(write_addr_a), .din(din_a),
        .re(re_a), .read_addr(read_addr_a), .rd_req_rdy(rd_req_rdy_a),
        .dout_vld(dout_vld_a), .dout(dout_a), .dout_rdy(dout_rdy_a)
    );

    ram_simple_dual_flow #(.W(16), .D(100), .RD_LAT(2), .BYPASS(0), .CLR_ON_RST(0)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr_b), .busy(busy_b),
        .we(we_b), .write_addr(write_addr_b), .din(din_b),
        .re(re_b), .read_addr(read_addr_b), .rd_req_rdy(rd_req_rdy_b),
        .dout_vld(dout_vld_b), .dout(dout_b), .dout_rdy(dout_rdy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_a(input logic [AW-1:0] addr, input logic [W-1:0] data);
        step();
        we_a = 1'b1; write_addr_a = addr; din_a = data;
        step();
        we_a = 1'b0;
    endtask

    task automatic wr_b(input logic [AW-1:0] addr, input logic [W-1:0] data);
        step();
        we_b = 1'b1; write_addr_b = addr; din_b = data;
        step();
        we_b = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
        step();
        re_a = 1'b1; read_addr_a = addr;
        @(negedge clk);
        check({tag, "_rdy"}, rd_req_rdy_a, 1);
        step();
        re_a = 1'b0;
        @(negedge clk);
        check({tag, "_vld"}, dout_vld_a, 1);
        check({tag, "_dout"}, dout_a, exp);
    endtask

    task automatic rd_b(input string tag, input logic [AW-1:0] addr, input logic [W-1:0] exp);
        step();
        re_b = 1'b1; read_addr_b = addr;
        @(negedge clk);
        check({tag, "_rdy"}, rd_req_rdy_b, 1);
        step();
        re_b = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, dout_vld_b, 0);
        step();
        @(negedge clk);
        check({tag, "_vld"}, dout_vld_b, 1);
        check({tag, "_dout"}, dout_b, exp);
    endtask

    initial begin
        int n, acc;
        rst = 1'b1;
        clr_a = 0; we_a = 0; re_a = 0; dout_rdy_a = 1; write_addr_a = '0; read_addr_a = '0; din_a = '0;
        clr_b = 0; we_b = 0; re_b = 0; dout_rdy_b = 1; write_addr_b = '0; read_addr_b = '0; din_b = '0;

        #3;
        check("rst_busy", busy_a, 0);
        check("rst_vld", dout_vld_a, 0);
        check("rst_dout", dout_a, 0);
        check("rst_rdy_a", rd_req_rdy_a, 0);
        check("rst_rdy_b", rd_req_rdy_b, 0);

        step();
        step();
        rst = 1'b0;

        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy_a) n++;
            else if (n > 0) break;
        end
        check("auto_clr_cycles", n, 128);

        rd_a("clr_rd0", 7'd0, 16'h0000);
        rd_a("clr_rd64", 7'd64, 16'h0000);
        rd_a("clr_rd127", 7'd127, 16'h0000);

        wr_a(7'd5, 16'hABCD);
        rd_a("rd5", 7'd5, 16'hABCD);

        wr_a(7'd9, 16'h1111);
        step();
        we_a = 1; write_addr_a = 7'd9; din_a = 16'h2222; re_a = 1; read_addr_a = 7'd9;
        step();
        we_a = 0; re_a = 0;
        @(negedge clk);
        check("byp_vld", dout_vld_a, 1);
        check("byp_dout", dout_a, 16'h2222);
        rd_a("byp_after", 7'd9, 16'h2222);

        wr_a(7'd20, 16'h00A0);
        wr_a(7'd21, 16'h00A1);
        wr_a(7'd22, 16'h00A2);
        step();
        dout_rdy_a = 0; re_a = 1; read_addr_a = 7'd20;
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (rd_req_rdy_a) acc++;
            step();
            read_addr_a = 7'(20 + acc);
        end
        check("bp_accepted", acc, 2);
        @(negedge clk);
        check("bp_rdy_low", rd_req_rdy_a, 0);
        check("bp_vld", dout_vld_a, 1);
        check("bp_hold", dout_a, 16'h00A0);
        step();
        dout_rdy_a = 1;
        @(negedge clk);
        check("bp_resume_rdy", rd_req_rdy_a, 1);
        check("bp_drain0", dout_a, 16'h00A0);
        step();
        re_a = 0;
        @(negedge clk);
        check("bp_drain1", dout_a, 16'h00A1);
        step();
        @(negedge clk);
        check("bp_drain2_vld", dout_vld_a, 1);
        check("bp_drain2", dout_a, 16'h00A2);
        step();
        re_a = 1; read_addr_a = 7'd20;
        @(negedge clk);
        check("tp_rdy0", rd_req_rdy_a, 1);
        check("tp_empty", dout_vld_a, 0);
        step();
        read_addr_a = 7'd21;
        @(negedge clk);
        check("tp_rdy1", rd_req_rdy_a, 1);
        check("tp_d0", dout_a, 16'h00A0);
        step();
        read_addr_a = 7'd22;
        @(negedge clk);
        check("tp_rdy2", rd_req_rdy_a, 1);
        check("tp_d1", dout_a, 16'h00A1);
        step();
        re_a = 0;
        @(negedge clk);
        check("tp_d2", dout_a, 16'h00A2);
        step();
        @(negedge clk);
        check("tp_done", dout_vld_a, 0);

        step();
        dout_rdy_a = 0; re_a = 1; read_addr_a = 7'd20;
        step();
        read_addr_a = 7'd21;
        step();
        re_a = 0; clr_a = 1;
        step();
        clr_a = 0;
        repeat (5) step();
        @(negedge clk);
        check("mid_clr_busy", busy_a, 1);
        check("mid_clr_vld", dout_vld_a, 1);
        dout_rdy_a = 1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", busy_a, 0);
        check("arst_vld", dout_vld_a, 0);
        check("arst_rdy", rd_req_rdy_a, 0);
        check("arst_dout", dout_a, 0);
        step();
        step();
        rst = 1'b0;
        n = 0;
        acc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dout_vld_a) acc++;
            if (busy_a) n++;
        end
        check("arst_stale_vld", acc, 0);
        check("arst_reclear", n, 128);

        step();
        clr_b = 1;
        n = 0;
        for (int i = 0; i < 150; i++) begin
            step();
            clr_b = (i == 9);
            @(negedge clk);
            if (busy_b) n++;
        end
        clr_b = 0;
        check("b_clr_cycles", n, 100);

        wr_b(7'd120, 16'hBEEF);
        rd_b("b_rd120", 7'd120, 16'h0000);
        rd_b("b_rd20", 7'd20, 16'h0000);
        rd_b("b_rd99", 7'd99, 16'h0000);

        wr_b(7'd9, 16'h1111);
        step();
        we_b = 1; write_addr_b = 7'd9; din_b = 16'h2222; re_b = 1; read_addr_b = 7'd9;
        @(negedge clk);
        check("b_old_rdy", rd_req_rdy_b, 1);
        step();
        we_b = 0; re_b = 0;
        step();
        @(negedge clk);
        check("b_old_vld", dout_vld_b, 1);
        check("b_old_dout", dout_b, 16'h1111);
        rd_b("b_new", 7'd9, 16'h2222);

        wr_b(7'd30, 16'h00C0);
        wr_b(7'd31, 16'h00C1);
        wr_b(7'd32, 16'h00C2);
        step();
        re_b = 1; read_addr_b = 7'd30;
        @(negedge clk);
        check("b_tp_rdy0", rd_req_rdy_b, 1);
        step();
        read_addr_b = 7'd31;
        @(negedge clk);
        check("b_tp_rdy1", rd_req_rdy_b, 1);
        step();
        read_addr_b = 7'd32;
        @(negedge clk);
        check("b_tp_rdy2", rd_req_rdy_b, 1);
        check("b_tp_d0", dout_b, 16'h00C0);
        step();
        re_b = 0;
        @(negedge clk);
        check("b_tp_d1", dout_b, 16'h00C1);
        step();
        @(negedge clk);
        check("b_tp_d2", dout_b, 16'h00C2);
        step();
        @(negedge clk);
        check("b_tp_done", dout_vld_b, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1);
    end

endmodule
